// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, P-register flag bit indices
// and a helper that assembles a flag byte in P-register layout.
package alu_pkg;

   typedef enum logic [2:0] {
      OpAdd = 3'b000,
      OpSub = 3'b001,
      OpAnd = 3'b010,
      OpOr  = 3'b011,
      OpEor = 3'b100,
      OpSl  = 3'b101,
      OpSr  = 3'b110,
      OpRsv = 3'b111
   } alu_op_e;

   localparam int unsigned FlagCarry    = 0;
   localparam int unsigned FlagZero     = 1;
   localparam int unsigned FlagIrq      = 2;
   localparam int unsigned FlagDecimal  = 3;
   localparam int unsigned FlagBreak    = 4;
   localparam int unsigned FlagUnused   = 5;
   localparam int unsigned FlagOverflow = 6;
   localparam int unsigned FlagNegative = 7;

   // Bit 5 always reads 1; I, D and B are owned by the core, not the ALU.
   localparam logic [7:0] FlagsReset = 8'h20;

   function automatic logic [7:0] make_flags(input logic n, input logic v,
                                             input logic z, input logic c);
      logic [7:0] f;
      f               = FlagsReset;
      f[FlagNegative] = n;
      f[FlagOverflow] = v;
      f[FlagZero]     = z;
      f[FlagCarry]    = c;
      return f;
   endfunction

endpackage

// File: rtl/bcd_adjust.sv
// Combinational decimal correction of a binary ADD/SUB result.
// For SUB, half_carry/carry are "no borrow" indications (1 = no borrow).
module bcd_adjust (
   input  logic [7:0] bin_sum,
   input  logic       half_carry,
   input  logic       carry,
   input  logic       sub,
   output logic [7:0] adj_y,
   output logic       adj_c
);

   logic [8:0] lo_fix;
   logic [7:0] lo_sub;
   logic       hi_fix;

   // Low-nibble then high-nibble correction; high check sees the low-adjusted value.
   always_comb begin
      lo_fix = {1'b0, bin_sum};
      lo_sub = bin_sum;
      hi_fix = 1'b0;
      adj_y  = bin_sum;
      adj_c  = carry;
      if (sub) begin
         if (!half_carry) lo_sub = bin_sum - 8'h06;
         adj_y = carry ? lo_sub : (lo_sub - 8'h60);
         adj_c = carry;
      end else begin
         if (half_carry || (bin_sum[3:0] > 4'd9)) lo_fix = {1'b0, bin_sum} + 9'h006;
         // lo_fix[8] covers the low fix rolling past FFh on non-BCD operands.
         hi_fix = carry || lo_fix[8] || (lo_fix[7:4] > 4'd9);
         adj_y  = hi_fix ? (lo_fix[7:0] + 8'h60) : lo_fix[7:0];
         adj_c  = hi_fix;
      end
   end

endmodule

// File: rtl/alu.sv
// Multi-cycle 8-bit ALU: binary result one cycle after start, decimal
// ADD/SUB take an extra correction cycle. All outputs are registered.
module alu
   import alu_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       alu_start,
   input  logic [2:0] alu_ctrl,
   input  logic [7:0] alu_AI,
   input  logic [7:0] alu_BI,
   input  logic       alu_carry,
   input  logic       alu_BCD,
   output logic [7:0] alu_Y,
   output logic [7:0] alu_flags,
   output logic       alu_busy,
   output logic       alu_valid
);

   typedef enum logic [2:0] {
      StIdle   = 3'b001,
      StBin    = 3'b010,
      StDecAdj = 3'b100
   } state_e;

   state_e     state_q;
   alu_op_e    op_q;
   logic [7:0] a_q, b_q;
   logic       c_q, bcd_q;

   // Binary result held for the decimal correction cycle.
   logic [7:0] sum_q;
   logic       hc_q, bin_c_q, bin_n_q, bin_v_q, bin_z_q;

   logic [7:0] b_eff;
   logic [8:0] bin_sum;
   logic [4:0] lo_sum;
   logic       bin_v, is_arith;
   logic [7:0] res_y;
   logic       res_c, res_v;
   logic [7:0] adj_y;
   logic       adj_c;

   // Binary datapath on the captured operands; SUB is A + ~B + carry.
   always_comb begin
      b_eff    = (op_q == OpSub) ? ~b_q : b_q;
      bin_sum  = {1'b0, a_q} + {1'b0, b_eff} + {8'b0, c_q};
      lo_sum   = {1'b0, a_q[3:0]} + {1'b0, b_eff[3:0]} + {4'b0, c_q};
      bin_v    = (a_q[7] == b_eff[7]) && (bin_sum[7] != a_q[7]);
      is_arith = (op_q == OpAdd) || (op_q == OpSub);
      res_y    = a_q;
      res_c    = 1'b0;
      res_v    = 1'b0;
      unique case (op_q)
         OpAdd, OpSub: begin
            res_y = bin_sum[7:0];
            res_c = bin_sum[8];
            res_v = bin_v;
         end
         OpAnd: res_y = a_q & b_q;
         OpOr:  res_y = a_q | b_q;
         OpEor: res_y = a_q ^ b_q;
         OpSl: begin
            res_y = {a_q[6:0], c_q};
            res_c = a_q[7];
         end
         OpSr: begin
            res_y = {c_q, a_q[7:1]};
            res_c = a_q[0];
         end
         OpRsv: begin
            res_y = a_q;
            res_c = c_q;
         end
      endcase
   end

   bcd_adjust u_bcd_adjust (
      .bin_sum    (sum_q),
      .half_carry (hc_q),
      .carry      (bin_c_q),
      .sub        (op_q == OpSub),
      .adj_y      (adj_y),
      .adj_c      (adj_c)
   );

   // Control FSM with registered result, flags, busy and valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         op_q      <= OpAdd;
         a_q       <= 8'h00;
         b_q       <= 8'h00;
         c_q       <= 1'b0;
         bcd_q     <= 1'b0;
         sum_q     <= 8'h00;
         hc_q      <= 1'b0;
         bin_c_q   <= 1'b0;
         bin_n_q   <= 1'b0;
         bin_v_q   <= 1'b0;
         bin_z_q   <= 1'b0;
         alu_Y     <= 8'h00;
         alu_flags <= FlagsReset;
         alu_busy  <= 1'b0;
         alu_valid <= 1'b0;
      end else begin
         alu_valid <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (alu_start) begin
                  op_q     <= alu_op_e'(alu_ctrl);
                  a_q      <= alu_AI;
                  b_q      <= alu_BI;
                  c_q      <= alu_carry;
                  bcd_q    <= alu_BCD;
                  alu_busy <= 1'b1;
                  state_q  <= StBin;
               end
            end
            StBin: begin
               if (is_arith && bcd_q) begin
                  sum_q   <= bin_sum[7:0];
                  hc_q    <= lo_sum[4];
                  bin_c_q <= bin_sum[8];
                  bin_n_q <= bin_sum[7];
                  bin_v_q <= bin_v;
                  bin_z_q <= (bin_sum[7:0] == 8'h00);
                  state_q <= StDecAdj;
               end else begin
                  alu_Y     <= res_y;
                  alu_flags <= make_flags(res_y[7], res_v, res_y == 8'h00, res_c);
                  alu_valid <= 1'b1;
                  alu_busy  <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            StDecAdj: begin
               // N/V/Z come from the uncorrected sum; only Y and C are corrected.
               alu_Y     <= adj_y;
               alu_flags <= make_flags(bin_n_q, bin_v_q, bin_z_q, adj_c);
               alu_valid <= 1'b1;
               alu_busy  <= 1'b0;
               state_q   <= StIdle;
            end
            default: begin
               alu_busy <= 1'b0;
               state_q  <= StIdle;
            end
         endcase
      end
   end

endmodule
